// File: rtl/pf_ar_arbiter_pkg.sv
// Shared types and width helpers for the prefetch / demand AR arbiter.
package pf_arb_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_DMD  = 2'd1,
    GNT_PF   = 2'd2
  } gnt_src_e;

  // Register width for a value range of n, never narrower than one bit
  function automatic int clog2w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pf_ar_arbiter_rr.sv
// Round-robin selector over N requesters; the pointer moves past the winner on advance.
module rr_arbiter
  import pf_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic [N-1:0]          req,
  input  logic                  advance,
  output logic [N-1:0]          gnt,
  output logic [clog2w(N)-1:0]  gnt_idx
);

  localparam int IW = clog2w(N);

  logic [IW-1:0] rr_ptr;
  logic          found;
  int            idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(rr_ptr) + i) % N;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

endmodule

// File: rtl/pf_ar_arbiter.sv
// AR port arbiter: fixed-priority demand, round-robin prefetch slices, starvation guard,
// and the registered AXI AR output stage.
module pf_ar_arbiter
  import pf_arb_pkg::*;
#(
  parameter int ADDR_BITS       = 64,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int TID_WIDTH       = 8,
  parameter int NUM_SLICES      = 4,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                                  clk,
  input  logic                                  resetN,
  input  logic                                  en,
  input  logic                                  pf_block,
  input  logic                                  dmd_ar_valid,
  output logic                                  dmd_ar_ready,
  input  logic [ADDR_BITS-1:0]                  dmd_ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0]            dmd_ar_len,
  input  logic [TID_WIDTH-1:0]                  dmd_ar_id,
  input  logic [NUM_SLICES-1:0]                 pf_req_valid,
  input  logic [NUM_SLICES*ADDR_BITS-1:0]       pf_req_addr,
  input  logic [NUM_SLICES*BURST_LEN_WIDTH-1:0] pf_req_len,
  input  logic [NUM_SLICES*TID_WIDTH-1:0]       pf_req_id,
  output logic [NUM_SLICES-1:0]                 pf_req_ack,
  output logic                                  m_ar_valid,
  input  logic                                  m_ar_ready,
  output logic [ADDR_BITS-1:0]                  m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0]            m_ar_len,
  output logic [TID_WIDTH-1:0]                  m_ar_id,
  output logic [1:0]                            gnt_src
);

  localparam int IW = clog2w(NUM_SLICES);
  localparam int SW = clog2w(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [NUM_SLICES-1:0]      pf_req_eff;
  logic [NUM_SLICES-1:0]      pf_gnt;
  logic [IW-1:0]              pf_gnt_idx;
  logic                       pf_pend;
  logic                       force_pf;
  logic                       load;
  logic                       sel_dmd;
  logic                       sel_pf;
  logic [SW-1:0]              starve_cnt;
  logic [ADDR_BITS-1:0]       pf_addr;
  logic [BURST_LEN_WIDTH-1:0] pf_len;
  logic [TID_WIDTH-1:0]       pf_id;
  gnt_src_e                   gnt_src_q;

  assign pf_req_eff = pf_req_valid & {NUM_SLICES{~pf_block}};
  assign pf_pend    = |pf_req_eff;
  assign force_pf   = (STARVE_LIMIT != 0) && pf_pend && (starve_cnt == STARVE_MAX);
  assign load       = en & (~m_ar_valid | m_ar_ready);
  assign sel_pf     = pf_pend & (force_pf | ~dmd_ar_valid);
  assign sel_dmd    = dmd_ar_valid & ~force_pf;

  assign dmd_ar_ready = load & sel_dmd;
  assign pf_req_ack   = (load & sel_pf) ? pf_gnt : '0;
  assign gnt_src      = gnt_src_q;

  rr_arbiter #(.N(NUM_SLICES)) u_rr (
    .clk     (clk),
    .resetN  (resetN),
    .req     (pf_req_eff),
    .advance (load & sel_pf),
    .gnt     (pf_gnt),
    .gnt_idx (pf_gnt_idx)
  );

  always_comb begin
    pf_addr = '0;
    pf_len  = '0;
    pf_id   = '0;
    for (int k = 0; k < NUM_SLICES; k++) begin
      if (pf_gnt[k]) begin
        pf_addr = pf_req_addr[k*ADDR_BITS +: ADDR_BITS];
        pf_len  = pf_req_len[k*BURST_LEN_WIDTH +: BURST_LEN_WIDTH];
        pf_id   = pf_req_id[k*TID_WIDTH +: TID_WIDTH];
      end
    end
  end

  // Starvation counts only demand wins made while a prefetch was actually waiting
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      starve_cnt <= '0;
    end else if (!pf_pend || (load && sel_pf)) begin
      starve_cnt <= '0;
    end else if (load && sel_dmd && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // AR output register: loads only when empty or draining, otherwise holds for AXI stability
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_ar_valid <= 1'b0;
      m_ar_addr  <= '0;
      m_ar_len   <= '0;
      m_ar_id    <= '0;
      gnt_src_q  <= GNT_NONE;
    end else if (load) begin
      if (sel_dmd) begin
        m_ar_valid <= 1'b1;
        m_ar_addr  <= dmd_ar_addr;
        m_ar_len   <= dmd_ar_len;
        m_ar_id    <= dmd_ar_id;
        gnt_src_q  <= GNT_DMD;
      end else if (sel_pf) begin
        m_ar_valid <= 1'b1;
        m_ar_addr  <= pf_addr;
        m_ar_len   <= pf_len;
        m_ar_id    <= pf_id;
        gnt_src_q  <= GNT_PF;
      end else begin
        m_ar_valid <= 1'b0;
        gnt_src_q  <= GNT_NONE;
      end
    end else if (m_ar_valid && m_ar_ready) begin
      m_ar_valid <= 1'b0;
      gnt_src_q  <= GNT_NONE;
    end
  end

endmodule

// File: tb/tb_pf_ar_arbiter.sv
// Scoreboard bench for pf_ar_arbiter: stimulus queues expected AR beats, a monitor checks them on handshake.
module tb_pf_ar_arbiter;
  import pf_arb_pkg::*;

  localparam int AB = 64;
  localparam int LB = 8;
  localparam int IB = 8;
  localparam int NS = 4;

  logic            clk = 1'b0;
  logic            resetN;
  logic            en;
  logic            pf_block;
  logic            dmd_ar_valid;
  logic            dmd_ar_ready;
  logic [AB-1:0]   dmd_ar_addr;
  logic [LB-1:0]   dmd_ar_len;
  logic [IB-1:0]   dmd_ar_id;
  logic [NS-1:0]   pf_req_valid;
  logic [NS*AB-1:0] pf_req_addr;
  logic [NS*LB-1:0] pf_req_len;
  logic [NS*IB-1:0] pf_req_id;
  logic [NS-1:0]   pf_req_ack;
  logic            m_ar_valid;
  logic            m_ar_ready;
  logic [AB-1:0]   m_ar_addr;
  logic [LB-1:0]   m_ar_len;
  logic [IB-1:0]   m_ar_id;
  logic [1:0]      gnt_src;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [7:0]  id;
    logic [1:0]  src;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  pf_ar_arbiter #(
    .ADDR_BITS(AB), .BURST_LEN_WIDTH(LB), .TID_WIDTH(IB),
    .NUM_SLICES(NS), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .resetN(resetN), .en(en), .pf_block(pf_block),
    .dmd_ar_valid(dmd_ar_valid), .dmd_ar_ready(dmd_ar_ready),
    .dmd_ar_addr(dmd_ar_addr), .dmd_ar_len(dmd_ar_len), .dmd_ar_id(dmd_ar_id),
    .pf_req_valid(pf_req_valid), .pf_req_addr(pf_req_addr),
    .pf_req_len(pf_req_len), .pf_req_id(pf_req_id), .pf_req_ack(pf_req_ack),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
    .m_ar_len(m_ar_len), .m_ar_id(m_ar_id), .gnt_src(gnt_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] slice_addr(input int k);
    return 64'hA000 + 64'h100 * 64'(k + 1);
  endfunction

  task automatic exp_dmd(input logic [63:0] a, input logic [7:0] l, input logic [7:0] i);
    exp_q.push_back('{addr: a, len: l, id: i, src: GNT_DMD});
  endtask

  task automatic exp_pf(input int k);
    exp_q.push_back('{addr: slice_addr(k), len: 8'(k + 1), id: 8'(8'h10 + k), src: GNT_PF});
  endtask

  // Monitor: compare each completed beat against the head of the scoreboard
  always @(negedge clk) begin
    if (resetN && m_ar_valid && m_ar_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", m_ar_addr, 64'hDEAD_DEAD);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat_addr", m_ar_addr, e.addr);
        chk("beat_len", 64'(m_ar_len), 64'(e.len));
        chk("beat_id", 64'(m_ar_id), 64'(e.id));
        chk("beat_src", 64'(gnt_src), 64'(e.src));
      end
    end
  end

  initial begin
    resetN = 1'b0; en = 1'b1; pf_block = 1'b0;
    dmd_ar_valid = 1'b0; dmd_ar_addr = '0; dmd_ar_len = '0; dmd_ar_id = '0;
    pf_req_valid = '0; m_ar_ready = 1'b1;
    for (int k = 0; k < NS; k++) begin
      pf_req_addr[k*AB +: AB] = slice_addr(k);
      pf_req_len[k*LB +: LB]  = 8'(k + 1);
      pf_req_id[k*IB +: IB]   = 8'(8'h10 + k);
    end
    tick(); tick();
    chk("reset_valid", 64'(m_ar_valid), 64'd0);
    chk("reset_src", 64'(gnt_src), 64'(GNT_NONE));
    chk("reset_addr", m_ar_addr, 64'd0);
    resetN = 1'b1;
    tick();

    // Demand only
    dmd_ar_valid = 1'b1; dmd_ar_addr = 64'h1000; dmd_ar_len = 8'd3; dmd_ar_id = 8'd5;
    #1;
    chk("dmd_ready", 64'(dmd_ar_ready), 64'd1);
    chk("dmd_no_pf_ack", 64'(pf_req_ack), 64'd0);
    exp_dmd(64'h1000, 8'd3, 8'd5);
    tick();
    dmd_ar_valid = 1'b0;
    chk("dmd_c1_valid", 64'(m_ar_valid), 64'd1);
    chk("dmd_c1_addr", m_ar_addr, 64'h1000);
    chk("dmd_c1_src", 64'(gnt_src), 64'(GNT_DMD));
    tick();
    chk("idle_valid", 64'(m_ar_valid), 64'd0);

    // Round-robin over all four slices
    pf_req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rr_ack", 64'(pf_req_ack), 64'(4'b0001 << (i % 4)));
      exp_pf(i % 4);
      tick();
    end
    pf_req_valid = '0;
    tick();

    // Starvation guard: slice 2 waits behind continuous demand
    pf_req_valid = 4'b0100; dmd_ar_valid = 1'b1; dmd_ar_len = 8'd1; dmd_ar_id = 8'd7;
    for (int i = 0; i < 10; i++) begin
      dmd_ar_addr = 64'h3000 + 64'(i) * 64'h40;
      #1;
      if (i == 4 || i == 9) begin
        chk("starve_pf_ack", 64'(pf_req_ack), 64'b0100);
        chk("starve_dmd_blk", 64'(dmd_ar_ready), 64'd0);
        exp_pf(2);
      end else begin
        chk("starve_dmd", 64'(dmd_ar_ready), 64'd1);
        chk("starve_no_ack", 64'(pf_req_ack), 64'd0);
        exp_dmd(dmd_ar_addr, 8'd1, 8'd7);
      end
      tick();
    end
    dmd_ar_valid = 1'b0; pf_req_valid = '0;
    tick();

    // Backpressure with a waiting demand request
    dmd_ar_valid = 1'b1; dmd_ar_addr = 64'h2040; dmd_ar_len = 8'd2; dmd_ar_id = 8'd9;
    #1;
    chk("bp_first_acc", 64'(dmd_ar_ready), 64'd1);
    exp_dmd(64'h2040, 8'd2, 8'd9);
    tick();
    m_ar_ready = 1'b0; dmd_ar_addr = 64'h2080; pf_req_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_no_dmd", 64'(dmd_ar_ready), 64'd0);
      chk("bp_no_pf", 64'(pf_req_ack), 64'd0);
      chk("bp_addr_hold", m_ar_addr, 64'h2040);
      chk("bp_valid_hold", 64'(m_ar_valid), 64'd1);
      tick();
    end
    m_ar_ready = 1'b1;
    #1;
    chk("bp_release_acc", 64'(dmd_ar_ready), 64'd1);
    exp_dmd(64'h2080, 8'd2, 8'd9);
    tick();
    dmd_ar_valid = 1'b0; pf_req_valid = '0;
    tick();

    // pf_block: prefetch ignored, demand unaffected and never forced aside
    pf_block = 1'b1; pf_req_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("blk_no_ack", 64'(pf_req_ack), 64'd0);
      tick();
    end
    chk("blk_valid", 64'(m_ar_valid), 64'd0);
    chk("blk_starve", 64'(dut.starve_cnt), 64'd0);
    dmd_ar_valid = 1'b1; dmd_ar_len = 8'd4; dmd_ar_id = 8'd3;
    for (int i = 0; i < 6; i++) begin
      dmd_ar_addr = 64'h4000 + 64'(i) * 64'h40;
      #1;
      chk("blk_dmd", 64'(dmd_ar_ready), 64'd1);
      exp_dmd(dmd_ar_addr, 8'd4, 8'd3);
      tick();
    end
    chk("blk_starve_dmd", 64'(dut.starve_cnt), 64'd0);
    dmd_ar_valid = 1'b0; pf_req_valid = '0; pf_block = 1'b0;
    tick();

    // en = 0 with a held beat
    dmd_ar_valid = 1'b1; dmd_ar_addr = 64'h5000; dmd_ar_len = 8'd0; dmd_ar_id = 8'd1;
    #1;
    exp_dmd(64'h5000, 8'd0, 8'd1);
    tick();
    en = 1'b0; m_ar_ready = 1'b0; dmd_ar_addr = 64'h5040;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("en_hold_noacc", 64'(dmd_ar_ready), 64'd0);
      chk("en_hold_valid", 64'(m_ar_valid), 64'd1);
      tick();
    end
    m_ar_ready = 1'b1;
    #1;
    chk("en_drain_noacc", 64'(dmd_ar_ready), 64'd0);
    tick();
    chk("en_drop_valid", 64'(m_ar_valid), 64'd0);
    tick();
    chk("en_stay_low", 64'(m_ar_valid), 64'd0);
    en = 1'b1;
    #1;
    chk("en_resume_acc", 64'(dmd_ar_ready), 64'd1);
    exp_dmd(64'h5040, 8'd0, 8'd1);
    tick();
    dmd_ar_valid = 1'b0;
    tick();

    // Asynchronous reset while a beat is held; rr pointer was left at slice 3
    m_ar_ready = 1'b0; dmd_ar_valid = 1'b1; dmd_ar_addr = 64'h7000;
    tick();
    dmd_ar_valid = 1'b0;
    chk("rst_pre_valid", 64'(m_ar_valid), 64'd1);
    #2;
    resetN = 1'b0;
    #1;
    chk("rst_async_valid", 64'(m_ar_valid), 64'd0);
    chk("rst_async_addr", m_ar_addr, 64'd0);
    chk("rst_async_src", 64'(gnt_src), 64'(GNT_NONE));
    tick(); tick();
    resetN = 1'b1;
    pf_req_valid = 4'b1111; m_ar_ready = 1'b1;
    #1;
    chk("rst_rr_slice0", 64'(pf_req_ack), 64'b0001);
    exp_pf(0);
    tick();
    pf_req_valid = '0;
    tick(); tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
